barrel_thread_scheduler: RTL and testbench

- Issue-slot scheduler for the multithreaded barrel core.
- Each cycle it rotates a thread slot, and for the selected thread it presents the program counter the fetch stage must use.
- Maintains a per-thread PC table, an active mask and an in-flight mask.
- Accepts start/stop commands from the host/loader, and accepts next-PC/halt writebacks from the final pipeline stage.

---
 rtl/barrel_thread_scheduler.sv | 156 +++++++++++++++
 tb/tb_barrel_thread_scheduler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/barrel_thread_scheduler.sv
// barrel_thread_scheduler
//   Issue-slot scheduler for the barrel core. A free-running slot counter
//   rotates over all hardware threads; each cycle the selected thread's PC
//   is presented to fetch together with whether that thread is running.
//   Keeps a per-thread PC table, an active mask and an in-flight mask.
//
// Ports
//   clk, resetn        core clock, asynchronous active-low reset
//   cmd_valid/ready    host command handshake (cmd_ready is combinational)
//   cmd_op             0 = START, 1 = STOP
//   cmd_tid, cmd_pc    target thread and start PC (START only)
//   wb_valid           writeback from the last pipeline stage
//   wb_tid, wb_next_pc thread and its next PC
//   wb_halt            thread executed ECALL/EBREAK, deactivate it
//   issue_valid/tid/pc registered issue slot for fetch
//   active_mask        running threads
//   all_idle           registered: nothing active and nothing in flight
//
// Optional build macro THREAD_SCHED_PERF_EN adds perf_tid (in) and
// perf_count (out, 32 bits): per-thread retired-instruction counters,
// cleared on reset and on an accepted START of that thread.
module barrel_thread_scheduler #(
   parameter int                    NUM_THREADS  = 32,
   parameter int                    PIPE_DEPTH   = 19,
   parameter int                    ADDR_WIDTH   = 11,
   parameter logic [ADDR_WIDTH-1:0] STARTUP_ADDR = '0
) (
   input  logic                           clk,
   input  logic                           resetn,
   input  logic                           cmd_valid,
   output logic                           cmd_ready,
   input  logic                           cmd_op,
   input  logic [$clog2(NUM_THREADS)-1:0] cmd_tid,
   input  logic [ADDR_WIDTH-1:0]          cmd_pc,
   input  logic                           wb_valid,
   input  logic [$clog2(NUM_THREADS)-1:0] wb_tid,
   input  logic [ADDR_WIDTH-1:0]          wb_next_pc,
   input  logic                           wb_halt,
`ifdef THREAD_SCHED_PERF_EN
   input  logic [$clog2(NUM_THREADS)-1:0] perf_tid,
   output logic [31:0]                    perf_count,
`endif
   output logic                           issue_valid,
   output logic [$clog2(NUM_THREADS)-1:0] issue_tid,
   output logic [ADDR_WIDTH-1:0]          issue_pc,
   output logic [NUM_THREADS-1:0]         active_mask,
   output logic                           all_idle
);

   localparam int TID_W = $clog2(NUM_THREADS);

   logic [TID_W-1:0]                        r_slot;
   logic [NUM_THREADS-1:0]                  r_active;
   logic [NUM_THREADS-1:0]                  r_inflight;
   logic [NUM_THREADS-1:0][ADDR_WIDTH-1:0]  r_pc;
   logic                                    r_issue_valid;
   logic [TID_W-1:0]                        r_issue_tid;
   logic [ADDR_WIDTH-1:0]                   r_issue_pc;
   logic                                    r_all_idle;

   logic w_start;
   logic w_stop;
   logic w_wb;

   // STOP is always taken; START waits until the thread is neither running
   // nor has an instruction still in the pipe.
   assign cmd_ready = cmd_op | (~r_active[cmd_tid] & ~r_inflight[cmd_tid]);
   assign w_start   = cmd_valid & ~cmd_op & cmd_ready;
   assign w_stop    = cmd_valid &  cmd_op;
   // A writeback only counts for a thread with an instruction in flight;
   // stale writebacks that straddle a reset are dropped here.
   assign w_wb      = wb_valid & r_inflight[wb_tid];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_slot        <= '0;
         r_active      <= '0;
         r_inflight    <= '0;
         r_pc          <= {NUM_THREADS{STARTUP_ADDR}};
         r_issue_valid <= 1'b0;
         r_issue_tid   <= '0;
         r_issue_pc    <= STARTUP_ADDR;
         r_all_idle    <= 1'b1;
      end else begin
         r_slot        <= r_slot + TID_W'(1);
         // Issue samples pre-edge state, so a same-cycle STOP still issues.
         r_issue_valid <= r_active[r_slot];
         r_issue_tid   <= r_slot;
         r_issue_pc    <= r_pc[r_slot];
         r_all_idle    <= (r_active == '0) && (r_inflight == '0);

         if (w_wb) begin
            r_pc[wb_tid]       <= wb_next_pc;
            r_inflight[wb_tid] <= 1'b0;
            if (wb_halt)
               r_active[wb_tid] <= 1'b0;
         end
         // Placed after the writeback so a fresh issue keeps its flag.
         if (r_active[r_slot])
            r_inflight[r_slot] <= 1'b1;
         // START cannot collide with a writeback on the same tid: it is
         // not ready while that thread is in flight.
         if (w_start) begin
            r_pc[cmd_tid]     <= cmd_pc;
            r_active[cmd_tid] <= 1'b1;
         end
         if (w_stop)
            r_active[cmd_tid] <= 1'b0;
      end
   end

   assign issue_valid = r_issue_valid;
   assign issue_tid   = r_issue_tid;
   assign issue_pc    = r_issue_pc;
   assign active_mask = r_active;
   assign all_idle    = r_all_idle;

`ifdef THREAD_SCHED_PERF_EN
   logic [NUM_THREADS-1:0][31:0] r_perf;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_perf <= '0;
      end else begin
         if (w_wb)
            r_perf[wb_tid] <= r_perf[wb_tid] + 32'd1;
         if (w_start)
            r_perf[cmd_tid] <= '0;
      end
   end

   assign perf_count = r_perf[perf_tid];
`endif

`ifndef SYNTHESIS
   // Issue history, PIPE_DEPTH deep, to check writeback timing.
   logic [PIPE_DEPTH-1:0]            r_hist_vld;
   logic [PIPE_DEPTH-1:0][TID_W-1:0] r_hist_tid;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_hist_vld <= '0;
         r_hist_tid <= '0;
      end else begin
         r_hist_vld <= {r_hist_vld[PIPE_DEPTH-2:0], r_issue_valid};
         r_hist_tid <= {r_hist_tid[PIPE_DEPTH-2:0], r_issue_tid};
      end
   end

   a_wb_inflight : assert property (@(posedge clk) disable iff (!resetn)
      wb_valid |-> r_inflight[wb_tid]);
   a_wb_latency  : assert property (@(posedge clk) disable iff (!resetn)
      wb_valid |-> (r_hist_vld[PIPE_DEPTH-1] && (r_hist_tid[PIPE_DEPTH-1] == wb_tid)));
`endif

endmodule

// File: tb/tb_barrel_thread_scheduler.sv
module tb_barrel_thread_scheduler;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_op = 1'b0;
   logic [4:0]  cmd_tid = '0;
   logic [10:0] cmd_pc = '0;
   logic        wb_valid = 1'b0;
   logic [4:0]  wb_tid = '0;
   logic [10:0] wb_next_pc = '0;
   logic        wb_halt = 1'b0;
   logic        issue_valid;
   logic [4:0]  issue_tid;
   logic [10:0] issue_pc;
   logic [31:0] active_mask;
   logic        all_idle;
`ifdef THREAD_SCHED_PERF_EN
   logic [4:0]  perf_tid = 5'd2;
   logic [31:0] perf_count;
`endif

   int n_cmp = 0;
   int n_err = 0;
   int k = 0;   // posedges since reset release

   always #5 clk = ~clk;

   barrel_thread_scheduler dut (
      .clk(clk), .resetn(resetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_tid(cmd_tid), .cmd_pc(cmd_pc),
      .wb_valid(wb_valid), .wb_tid(wb_tid), .wb_next_pc(wb_next_pc), .wb_halt(wb_halt),
`ifdef THREAD_SCHED_PERF_EN
      .perf_tid(perf_tid), .perf_count(perf_count),
`endif
      .issue_valid(issue_valid), .issue_tid(issue_tid), .issue_pc(issue_pc),
      .active_mask(active_mask), .all_idle(all_idle)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s (k=%0d): got %h want %h", tag, k, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      k++;
   endtask

   task automatic go_to(input int n);
      while (k < n) tick();
   endtask

   task automatic cmd(input logic op, input logic [4:0] tid, input logic [10:0] pc);
      cmd_valid = 1'b1; cmd_op = op; cmd_tid = tid; cmd_pc = pc;
      #1;
   endtask

   task automatic wb(input logic [4:0] tid, input logic [10:0] npc, input logic halt);
      wb_valid = 1'b1; wb_tid = tid; wb_next_pc = npc; wb_halt = halt;
   endtask

   task automatic idle_inputs();
      cmd_valid = 1'b0; wb_valid = 1'b0; wb_halt = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", issue_valid, 0);
      chk("rst_tid",   issue_tid,   0);
      chk("rst_pc",    issue_pc,    0);
      chk("rst_idle",  all_idle,    1);
      chk("rst_mask",  active_mask, 0);
      resetn = 1'b1;

      // free-running rotation, nothing active
      for (int i = 0; i < 64; i++) begin
         tick();
         chk("rot_tid",   issue_tid,   (k - 1) % 32);
         chk("rot_valid", issue_valid, 0);
         chk("rot_idle",  all_idle,    1);
      end

      // START tid 5 @0x040 (slot counter is 0 here)
      cmd(1'b0, 5'd5, 11'h040);
      chk("st5_ready", cmd_ready, 1);
      tick(); idle_inputs();
      chk("st5_mask", active_mask, 32'h0000_0020);
      tick();
      chk("st5_idle", all_idle, 0);
      go_to(69);
      chk("pre5_valid", issue_valid, 0);
      tick();
      chk("iss5a_tid",   issue_tid,   5);
      chk("iss5a_valid", issue_valid, 1);
      chk("iss5a_pc",    issue_pc,    11'h040);
      // START on an active thread is refused
      go_to(75);
      cmd(1'b0, 5'd5, 11'h111);
      chk("st5_busy", cmd_ready, 0);
      idle_inputs();
      go_to(89);
      wb(5'd5, 11'h041, 1'b0);
      tick(); idle_inputs();
      go_to(102);
      chk("iss5b_valid", issue_valid, 1);
      chk("iss5b_pc",    issue_pc,    11'h041);
      // STOP while in flight
      go_to(110);
      cmd(1'b1, 5'd5, 11'h000);
      chk("sp5_ready", cmd_ready, 1);
      tick(); idle_inputs();
      chk("sp5_mask", active_mask, 0);
      go_to(121);
      wb(5'd5, 11'h042, 1'b0);
      tick(); idle_inputs();
      chk("sp5_idle0", all_idle, 0);
      tick();
      chk("sp5_idle1", all_idle, 1);
      go_to(134);
      chk("iss5c_tid",   issue_tid,   5);
      chk("iss5c_valid", issue_valid, 0);
      chk("iss5c_pc",    issue_pc,    11'h042);

      // halt on tid 3 @0x100
      cmd(1'b0, 5'd3, 11'h100);
      chk("st3_ready", cmd_ready, 1);
      tick(); idle_inputs();
      go_to(164);
      chk("iss3_valid", issue_valid, 1);
      chk("iss3_pc",    issue_pc,    11'h100);
      go_to(183);
      wb(5'd3, 11'h104, 1'b1);
      tick(); idle_inputs();
      chk("h3_mask",  active_mask, 0);
      chk("h3_idle0", all_idle,    0);
      tick();
      chk("h3_idle1", all_idle,    1);
      go_to(196);
      chk("h3_valid", issue_valid, 0);
      chk("h3_pc",    issue_pc,    11'h104);

      // STOP and halting writeback on tid 7 in the same cycle
      cmd(1'b0, 5'd7, 11'h180);
      tick(); idle_inputs();
      go_to(200);
      chk("iss7_valid", issue_valid, 1);
      chk("iss7_pc",    issue_pc,    11'h180);
      go_to(219);
      wb(5'd7, 11'h1F0, 1'b1);
      cmd(1'b1, 5'd7, 11'h000);
      tick(); idle_inputs();
      chk("c7_mask", active_mask, 0);
      cmd_op = 1'b0; cmd_tid = 5'd7; #1;
      chk("c7_ready", cmd_ready, 1);
      go_to(232);
      chk("c7_valid", issue_valid, 0);
      chk("c7_pc",    issue_pc,    11'h1F0);
      cmd(1'b0, 5'd7, 11'h200);
      chk("c7_restart_ready", cmd_ready, 1);
      tick(); idle_inputs();
      chk("c7_restart_mask", active_mask, 32'h0000_0080);
      // STOP lands on the same edge that issues tid 7
      go_to(263);
      cmd(1'b1, 5'd7, 11'h000);
      tick(); idle_inputs();
      chk("si7_tid",   issue_tid,   7);
      chk("si7_valid", issue_valid, 1);
      chk("si7_pc",    issue_pc,    11'h200);
      chk("si7_mask",  active_mask, 0);
      go_to(283);
      wb(5'd7, 11'h201, 1'b0);
      tick(); idle_inputs();
      chk("si7_idle0", all_idle, 0);
      tick();
      chk("si7_idle1", all_idle, 1);

`ifdef THREAD_SCHED_PERF_EN
      // retired-instruction counter on tid 2
      cmd(1'b0, 5'd2, 11'h300);
      tick(); idle_inputs();
      chk("pf_start0", perf_count, 0);
      for (int i = 0; i < 10; i++) begin
         go_to(291 + 32 * i);
         chk("pf_iss_valid", issue_valid, 1);
         chk("pf_iss_pc",    issue_pc,    32'h300 + i);
         go_to(310 + 32 * i);
         wb(5'd2, 11'(11'h301 + i), 1'b0);
         tick(); idle_inputs();
         if (i == 0) chk("pf_one", perf_count, 1);
      end
      chk("pf_ten", perf_count, 10);
      cmd(1'b1, 5'd2, 11'h000);
      tick(); idle_inputs();
      chk("pf_stop_keep", perf_count, 10);
      cmd(1'b0, 5'd2, 11'h000);
      chk("pf_restart_ready", cmd_ready, 1);
      tick(); idle_inputs();
      chk("pf_clear", perf_count, 0);
`endif

      // asynchronous reset mid-operation
      cmd(1'b0, 5'd9, 11'h055);
      tick(); idle_inputs();
      chk("pre_rst_mask", active_mask[9], 1);
      #2;
      resetn = 1'b0;
      #1;
      chk("mid_rst_mask",  active_mask, 0);
      chk("mid_rst_idle",  all_idle,    1);
      chk("mid_rst_valid", issue_valid, 0);
      chk("mid_rst_tid",   issue_tid,   0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
